// File: rtl/serial_subtractor_ctrl_if.sv
// serial_subtractor_ctrl_if: start/done handshake and operand/result bus for the serial subtractor
interface serial_subtractor_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    modport master (output start, a, b, input busy, done, diff, borrow_out);
    modport slave (input start, a, b, output busy, done, diff, borrow_out);
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: computes a-b bit-serially, LSB first, with one 1-bit subtractor cell
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    serial_subtractor_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] a_sr, b_sr, diff_q, res_n;
    logic [WIDTH-2:0] res;
    logic [CW-1:0]    count;
    logic             bor, borrow_q, d, bor_next;
    always_comb begin
        d        = a_sr[0] ^ b_sr[0] ^ bor;
        bor_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bor);
        res_n    = {d, res};
        state_n  = state == IDLE ? (bus.start ? RUN : IDLE) :
                   state == RUN  ? (count == LAST ? DONE : RUN) : IDLE;
    end
    // res keeps only the upper WIDTH-1 result bits; res_n is the full result after this step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res      <= '0;
            bor      <= 1'b0;
            count    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && bus.start) begin
                a_sr  <= bus.a;
                b_sr  <= bus.b;
                bor   <= 1'b0;
                count <= '0;
            end else if (state == RUN) begin
                a_sr  <= a_sr >> 1;
                b_sr  <= b_sr >> 1;
                res   <= res_n[WIDTH-1:1];
                bor   <= bor_next;
                count <= count + 1'b1;
                if (count == LAST) begin
                    diff_q   <= res_n;
                    borrow_q <= bor_next;
                end
            end
        end
    end
    assign bus.busy       = state == RUN;
    assign bus.done       = state == DONE;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl: directed and random checks of the serial subtractor controller
module tb_serial_subtractor_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    int overlap = 0;
    serial_subtractor_ctrl_if #(.WIDTH(8)) bus ();
    serial_subtractor_ctrl #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(negedge clk) if (bus.done && bus.busy) overlap++;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = av;
        bus.b = bv;
        @(negedge clk);
        bus.start = 1'b0;
    endtask
    task automatic wait_done(output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        while (!bus.done && n < 40) begin
            if (bus.busy) busy_n++;
            @(negedge clk);
            n++;
        end
    endtask
    task automatic directed(input string tag, input logic [7:0] av, input logic [7:0] bv,
                            input logic [7:0] ed, input logic eb);
        int n, bn;
        start_op(av, bv);
        wait_done(n, bn);
        chk({tag, "_lat"}, n, 8);
        chk({tag, "_busy"}, bn, 8);
        chk({tag, "_diff"}, bus.diff, ed);
        chk({tag, "_bor"}, bus.borrow_out, eb);
        @(negedge clk);
        chk({tag, "_pulse"}, bus.done, 0);
    endtask
    initial begin
        int n, bn, seen;
        logic [7:0] ra, rb;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_diff", bus.diff, 0);
        chk("rst_bor", bus.borrow_out, 0);
        #20 rst_n = 1'b1;
        directed("t35_12", 8'h35, 8'h12, 8'h23, 1'b0);
        directed("t12_35", 8'h12, 8'h35, 8'hDD, 1'b1);
        directed("t00_01", 8'h00, 8'h01, 8'hFF, 1'b1);
        directed("tFF_FF", 8'hFF, 8'hFF, 8'h00, 1'b0);
        // back-to-back with start held and operands changed after the accept
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'h10;
        bus.b = 8'h01;
        @(negedge clk);
        bus.a = 8'h80;
        bus.b = 8'h01;
        wait_done(n, bn);
        chk("b2b_lat1", n, 8);
        chk("b2b_diff1", bus.diff, 8'h0F);
        @(negedge clk);
        chk("b2b_idle", bus.busy, 0);
        @(negedge clk);
        chk("b2b_accept10", bus.busy, 1);
        bus.start = 1'b0;
        wait_done(n, bn);
        chk("b2b_lat2", n, 8);
        chk("b2b_diff2", bus.diff, 8'h7F);
        chk("b2b_bor2", bus.borrow_out, 0);
        @(negedge clk);
        // start and operand changes during RUN and DONE are ignored
        start_op(8'h5A, 8'h0F);
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'h00;
        bus.b = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n, bn);
        chk("ign_diff", bus.diff, 8'h4B);
        chk("ign_bor", bus.borrow_out, 0);
        bus.start = 1'b1;
        bus.a = 8'h01;
        bus.b = 8'h02;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ign_done_once", bus.done, 0);
        chk("ign_no_accept", bus.busy, 0);
        @(negedge clk);
        chk("ign_idle", bus.busy, 0);
        chk("hold_diff", bus.diff, 8'h4B);
        // reset after four RUN edges aborts without a done pulse
        start_op(8'h77, 8'h11);
        repeat (4) @(negedge clk);
        chk("mid_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("ar_busy", bus.busy, 0);
        chk("ar_diff", bus.diff, 0);
        chk("ar_bor", bus.borrow_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        chk("ar_no_done", seen, 0);
        directed("t09_03", 8'h09, 8'h03, 8'h06, 1'b0);
        for (int i = 0; i < 500; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            start_op(ra, rb);
            wait_done(n, bn);
            chk("rnd_diff", bus.diff, 32'(8'(ra - rb)));
            chk("rnd_bor", bus.borrow_out, 32'(ra < rb));
        end
        chk("no_overlap", overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
